// File: rtl/key_loader.sv
// Serial key loader for a logic-locked netlist: shifts in KEY_W key bits plus an
// even-parity bit, verifies length and parity on commit, and applies the key once.
module key_loader #(
  parameter int KEY_W     = 64,
  parameter int MAX_TRIES = 3
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             KEY_SI,
  input  logic             KEY_SE,
  input  logic             KEY_LOAD,
  input  logic             KEY_CLR,
  output logic [KEY_W-1:0] KEY_OUT,
  output logic             KEY_READY,
  output logic             KEY_ERR,
  output logic             KEY_BLOCKED,
  output logic             BUSY
);

  localparam int CNT_W  = $clog2(KEY_W + 3);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(KEY_W + 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(KEY_W + 2);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CHECK, S_LOCKED, S_ERROR, S_BLOCKED
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [KEY_W:0]      r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic [FAIL_W-1:0]   r_fail;
  logic [KEY_W-1:0]    r_key;
  logic                r_ready;
  logic                w_pass;
  logic                w_last_try;
  logic [FAIL_W-1:0]   w_fail_inc;

  assign w_pass     = (r_cnt == CNT_FULL) && !(^r_sr);
  assign w_fail_inc = r_fail + FAIL_W'(1);
  assign w_last_try = (w_fail_inc >= FAIL_MAX);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (KEY_LOAD)    w_next = S_CHECK;
        else if (KEY_SE) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (KEY_LOAD) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_pass)          w_next = S_LOCKED;
        else if (w_last_try) w_next = S_BLOCKED;
        else                 w_next = S_ERROR;
      end
      S_LOCKED:  w_next = S_LOCKED;
      S_ERROR: begin
        if (KEY_CLR) w_next = S_IDLE;
      end
      S_BLOCKED: w_next = S_BLOCKED;
      default:   w_next = S_IDLE;
    endcase
  end

  // The key reaches the gates one cycle after LOCKED is entered; only reset leaves LOCKED.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_fail  <= '0;
      r_key   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!KEY_LOAD && KEY_SE) begin
            r_sr  <= {{KEY_W{1'b0}}, KEY_SI};
            r_cnt <= CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (!KEY_LOAD && KEY_SE) begin
            r_sr <= {r_sr[KEY_W-1:0], KEY_SI};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (w_pass) begin
            r_fail <= '0;
          end else begin
            r_fail <= w_fail_inc;
            r_sr   <= '0;
            r_cnt  <= '0;
          end
        end
        S_LOCKED: begin
          r_key   <= r_sr[KEY_W:1];
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign KEY_OUT     = r_key;
  assign KEY_READY   = r_ready;
  assign KEY_ERR     = (r_state == S_ERROR);
  assign KEY_BLOCKED = (r_state == S_BLOCKED);
  assign BUSY        = (r_state == S_SHIFT) || (r_state == S_CHECK);

endmodule

// File: tb/tb_key_loader.sv
// Scoreboarded bench for key_loader with an 8-bit key: commits push the expected
// outcome, a negedge monitor pops it when READY/ERR/BLOCKED rises.
module tb_key_loader;

  localparam int KW = 8;

  logic          CLK;
  logic          RN;
  logic          KEY_SI;
  logic          KEY_SE;
  logic          KEY_LOAD;
  logic          KEY_CLR;
  logic [KW-1:0] KEY_OUT;
  logic          KEY_READY;
  logic          KEY_ERR;
  logic          KEY_BLOCKED;
  logic          BUSY;

  key_loader #(.KEY_W(KW), .MAX_TRIES(3)) dut (
    .CLK(CLK), .RN(RN), .KEY_SI(KEY_SI), .KEY_SE(KEY_SE),
    .KEY_LOAD(KEY_LOAD), .KEY_CLR(KEY_CLR), .KEY_OUT(KEY_OUT),
    .KEY_READY(KEY_READY), .KEY_ERR(KEY_ERR), .KEY_BLOCKED(KEY_BLOCKED),
    .BUSY(BUSY)
  );

  typedef struct {
    logic [KW-1:0] key;
    logic          rdy;
    logic          err;
    logic          blk;
    int            cyc;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always_ff @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sends v[n-1] first; optionally leaves a two-cycle SE gap mid-stream.
  task automatic shift_bits(input logic [15:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      KEY_SE = 1'b1;
      KEY_SI = v[i];
      tick();
      if (gap && i == 4) begin
        KEY_SE = 1'b0;
        tick();
        tick();
      end
    end
    KEY_SE = 1'b0;
    KEY_SI = 1'b0;
  endtask

  task automatic push(input string nm, input logic [KW-1:0] key, input logic rdy,
                      input logic err, input logic blk, input int lat);
    exp_t e;
    e.key  = key;
    e.rdy  = rdy;
    e.err  = err;
    e.blk  = blk;
    e.cyc  = cyc + 1 + lat;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic load_pulse();
    KEY_LOAD = 1'b1;
    tick();
    KEY_LOAD = 1'b0;
  endtask

  task automatic clr_pulse();
    KEY_CLR = 1'b1;
    tick();
    KEY_CLR = 1'b0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drops RN in the middle of a clock cycle and releases it right after an edge.
  task automatic mid_reset(input bit do_chk);
    @(posedge CLK);
    #3;
    RN = 1'b0;
    #1;
    if (do_chk) begin
      chk("async_rst_key_out", 32'(KEY_OUT), 32'h0);
      chk("async_rst_ready", 32'(KEY_READY), 32'h0);
    end
    tick();
    RN = 1'b1;
  endtask

  initial begin : monitor
    logic ev;
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RN) begin
        prev = 1'b0;
      end else begin
        ev = KEY_READY | KEY_ERR | KEY_BLOCKED;
        if (ev && !prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", {29'b0, KEY_READY, KEY_ERR, KEY_BLOCKED}, 32'h0);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_key"},   32'(KEY_OUT),     32'(e.key));
            chk({e.name, "_ready"}, 32'(KEY_READY),   32'(e.rdy));
            chk({e.name, "_err"},   32'(KEY_ERR),     32'(e.err));
            chk({e.name, "_blk"},   32'(KEY_BLOCKED), 32'(e.blk));
            chk({e.name, "_cycle"}, 32'(cyc),         32'(e.cyc));
          end
        end
        prev = ev;
      end
    end
  end

  initial begin : stim
    RN = 1'b0; KEY_SI = 1'b0; KEY_SE = 1'b0; KEY_LOAD = 1'b0; KEY_CLR = 1'b0;
    #3;
    chk("rst_key_out", 32'(KEY_OUT), 32'h0);
    chk("rst_ready", 32'(KEY_READY), 32'h0);
    chk("rst_err", 32'(KEY_ERR), 32'h0);
    chk("rst_blocked", 32'(KEY_BLOCKED), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    tick();
    tick();
    RN = 1'b1;
    tick();

    // Good load B2 with even parity, with a gap in the stream.
    shift_bits(16'h0164, 9, 1'b1);
    chk("shift_busy", 32'(BUSY), 32'h1);
    push("good", 8'hB2, 1'b1, 1'b0, 1'b0, 2);
    load_pulse();
    wait_n(3);
    chk("good_busy", 32'(BUSY), 32'h0);
    chk("good_out", 32'(KEY_OUT), 32'hB2);

    // Tamper attempt while locked.
    shift_bits(16'h01FE, 9, 1'b0);
    load_pulse();
    clr_pulse();
    wait_n(3);
    chk("tamper_out", 32'(KEY_OUT), 32'hB2);
    chk("tamper_ready", 32'(KEY_READY), 32'h1);
    chk("tamper_busy", 32'(BUSY), 32'h0);
    mid_reset(1'b1);

    // Parity failure, acknowledge, then a correct reload.
    shift_bits(16'h0165, 9, 1'b0);
    push("parity_bad", 8'h00, 1'b0, 1'b1, 1'b0, 1);
    load_pulse();
    wait_n(2);
    KEY_SE = 1'b1; KEY_SI = 1'b1; KEY_LOAD = 1'b1;
    tick();
    KEY_SE = 1'b0; KEY_SI = 1'b0; KEY_LOAD = 1'b0;
    chk("err_holds", 32'(KEY_ERR), 32'h1);
    chk("err_key_out", 32'(KEY_OUT), 32'h0);
    clr_pulse();
    chk("clr_err", 32'(KEY_ERR), 32'h0);
    chk("clr_busy", 32'(BUSY), 32'h0);
    shift_bits(16'h0164, 9, 1'b0);
    push("reload", 8'hB2, 1'b1, 1'b0, 1'b0, 2);
    load_pulse();
    wait_n(3);
    mid_reset(1'b0);

    // Length errors: short and overflow streams whose parity is even.
    shift_bits(16'h0014, 5, 1'b0);
    push("short5", 8'h00, 1'b0, 1'b1, 1'b0, 1);
    load_pulse();
    wait_n(2);
    clr_pulse();
    shift_bits(16'h0764, 11, 1'b0);
    push("over11", 8'h00, 1'b0, 1'b1, 1'b0, 1);
    load_pulse();
    wait_n(2);
    mid_reset(1'b0);

    push("empty", 8'h00, 1'b0, 1'b1, 1'b0, 1);
    load_pulse();
    wait_n(2);
    clr_pulse();
    // Parity bit arrives together with the load strobe and must be dropped.
    shift_bits(16'h00B2, 8, 1'b0);
    KEY_SE = 1'b1; KEY_SI = 1'b0; KEY_LOAD = 1'b1;
    push("se_and_load", 8'h00, 1'b0, 1'b1, 1'b0, 1);
    tick();
    KEY_SE = 1'b0; KEY_LOAD = 1'b0;
    wait_n(2);
    mid_reset(1'b0);

    // Lockout after three bad commits.
    for (int t = 0; t < 3; t++) begin
      shift_bits(16'h0165, 9, 1'b0);
      if (t < 2) push("bad_try", 8'h00, 1'b0, 1'b1, 1'b0, 1);
      else       push("lockout", 8'h00, 1'b0, 1'b0, 1'b1, 1);
      load_pulse();
      wait_n(2);
      if (t < 2) clr_pulse();
    end
    clr_pulse();
    chk("blk_after_clr", 32'(KEY_BLOCKED), 32'h1);
    shift_bits(16'h0164, 9, 1'b0);
    load_pulse();
    wait_n(3);
    chk("blk_ignores_key", 32'(KEY_BLOCKED), 32'h1);
    chk("blk_ready", 32'(KEY_READY), 32'h0);
    chk("blk_key_out", 32'(KEY_OUT), 32'h0);
    chk("blk_busy", 32'(BUSY), 32'h0);
    mid_reset(1'b0);
    chk("unblock_rst", 32'(KEY_BLOCKED), 32'h0);

    shift_bits(16'h0164, 9, 1'b0);
    push("after_unblock", 8'hB2, 1'b1, 1'b0, 1'b0, 2);
    load_pulse();
    wait_n(3);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
